shadow_register_restore_controller: RTL and testbench

Restore-side counterpart of the shadow-register save path. On an interrupt return (mret) from the issue stage, it reloads the NUM_SHADOW_SAVES interrupt-context words from the machine-mode stack through a dcache load port. It writes each returned word into the shadow register file write port and then hands the popped stack pointer back. It sits between the issue stage / dcache load port and the shadow register file, and consumes the stack frame the save controller produced.

---
 rtl/shadow_register_restore_controller.sv | 161 ++++++++++++++++
 tb/tb_shadow_register_restore_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_register_restore_controller.sv
// Shadow-register restore controller.
// On an mret restore trigger, reloads NUM_SHADOW_SAVES context words from the
// machine-mode stack frame through a dcache load port, writes each returned
// word into the shadow register file, then reports the popped stack pointer.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   restore_i / restore_sp_i      restore trigger and frame base address
//   restore_ready_o / _done_o     idle indication, completion pulse
//   restore_sp_o                  popped stack pointer (base + frame size)
//   dreq_* / drsp_*               dcache load request/grant and in-order response
//   shadow_reg_*                  shadow register file write port
//   page_offset_i / _matches_o    LSU page offset overlap with the active frame
module shadow_register_restore_controller #(
   parameter int unsigned ADDR_WIDTH       = 6,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned NUM_SHADOW_SAVES = 16,
   parameter int unsigned MAX_OUTSTANDING  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  restore_i,
   input  logic [DATA_WIDTH-1:0] restore_sp_i,
   output logic                  restore_ready_o,
   output logic                  restore_done_o,
   output logic [DATA_WIDTH-1:0] restore_sp_o,
   output logic                  dreq_req_o,
   output logic [DATA_WIDTH-1:0] dreq_addr_o,
   input  logic                  dreq_gnt_i,
   input  logic                  drsp_valid_i,
   input  logic [DATA_WIDTH-1:0] drsp_data_i,
   output logic                  shadow_reg_we_o,
   output logic [ADDR_WIDTH-1:0] shadow_reg_waddr_o,
   output logic [DATA_WIDTH-1:0] shadow_reg_wdata_o,
   input  logic [11:0]           page_offset_i,
   output logic                  page_offset_matches_o
);

   localparam int unsigned W           = DATA_WIDTH / 8;
   localparam int unsigned OFF_W       = $clog2(W);
   localparam int unsigned CNT_W       = $clog2(NUM_SHADOW_SAVES + 1);
   localparam int unsigned FRAME_BYTES = NUM_SHADOW_SAVES * W;
   localparam int unsigned LAST_OFF    = (NUM_SHADOW_SAVES - 1) * W;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] base_q;
   logic [DATA_WIDTH-1:0] sp_out_q;
   logic [CNT_W-1:0]      req_cnt_q;
   logic [CNT_W-1:0]      rsp_cnt_q;
   logic                  done_q;

   logic [CNT_W-1:0]      outstanding;
   logic                  req_c;
   logic                  gnt_acc;
   logic                  rsp_acc;

   // Request throttling: stop at end of frame or at the outstanding limit.
   assign outstanding = req_cnt_q - rsp_cnt_q;
   assign req_c   = (state_q == LOAD) && (req_cnt_q < CNT_W'(NUM_SHADOW_SAVES))
                    && (32'(outstanding) < MAX_OUTSTANDING);
   assign gnt_acc = req_c && dreq_gnt_i;
   // Responses only count against a load that is actually outstanding.
   assign rsp_acc = (state_q == LOAD) && drsp_valid_i && (rsp_cnt_q < req_cnt_q);

   // State, frame base, counters and result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         base_q    <= '0;
         sp_out_q  <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (restore_i) begin
                  base_q    <= restore_sp_i & ~DATA_WIDTH'(W - 1);
                  req_cnt_q <= '0;
                  rsp_cnt_q <= '0;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
               if (gnt_acc) begin
                  req_cnt_q <= req_cnt_q + CNT_W'(1);
               end
               if (rsp_acc) begin
                  rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
                  // Last word written: pulse done and publish the popped SP.
                  if (rsp_cnt_q == CNT_W'(NUM_SHADOW_SAVES - 1)) begin
                     done_q   <= 1'b1;
                     sp_out_q <= base_q + DATA_WIDTH'(FRAME_BYTES);
                     state_q  <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign restore_ready_o    = (state_q == IDLE);
   assign restore_done_o     = done_q;
   assign restore_sp_o       = sp_out_q;
   assign dreq_req_o         = req_c;
   assign dreq_addr_o        = base_q + (DATA_WIDTH'(req_cnt_q) << OFF_W);
   assign shadow_reg_we_o    = rsp_acc;
   assign shadow_reg_waddr_o = ADDR_WIDTH'(rsp_cnt_q);
   assign shadow_reg_wdata_o = drsp_data_i;

   // Frame overlap on 8-byte granules within the page; the range may wrap.
   logic [11:0] last_lo;
   logic [8:0]  first_idx;
   logic [8:0]  last_idx;
   logic [8:0]  off_idx;
   logic        in_range;
   logic        unused_bits;

   assign last_lo   = base_q[11:0] + 12'(LAST_OFF);
   assign first_idx = base_q[11:3];
   assign last_idx  = last_lo[11:3];
   assign off_idx   = page_offset_i[11:3];
   assign in_range  = (last_idx >= first_idx)
                      ? ((off_idx >= first_idx) && (off_idx <= last_idx))
                      : ((off_idx >= first_idx) || (off_idx <= last_idx));
   assign page_offset_matches_o = (state_q == LOAD) && in_range;
   assign unused_bits = ^{page_offset_i[2:0], last_lo[2:0]};

`ifndef SYNTHESIS
   logic                  req_prev_q;
   logic                  gnt_prev_q;
   logic [DATA_WIDTH-1:0] addr_prev_q;

   // Protocol checks; misuse by the issue stage or dcache is tolerated but reported.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_prev_q  <= 1'b0;
         gnt_prev_q  <= 1'b0;
         addr_prev_q <= '0;
      end else begin
         req_prev_q  <= dreq_req_o;
         gnt_prev_q  <= dreq_gnt_i;
         addr_prev_q <= dreq_addr_o;
         assert (!(restore_i && (state_q != IDLE)))
            else $warning("restore_i ignored: restore already in progress");
         assert (!(drsp_valid_i && !rsp_acc))
            else $warning("drsp_valid_i ignored: no load outstanding");
         assert (!(req_prev_q && !gnt_prev_q) || (dreq_req_o && (dreq_addr_o == addr_prev_q)))
            else $error("dreq_req_o/dreq_addr_o changed before grant");
         assert (32'(outstanding) <= MAX_OUTSTANDING)
            else $error("outstanding loads exceed limit");
      end
   end
`endif

endmodule

// File: tb/tb_shadow_register_restore_controller.sv
// Directed bench for shadow_register_restore_controller: a dcache responder
// model, a write scoreboard filled at grant time and drained on shadow writes,
// and a linear sequence of restore scenarios.
module tb_shadow_register_restore_controller;

   localparam int unsigned AW   = 6;
   localparam int unsigned DW   = 32;
   localparam int unsigned NUM  = 16;
   localparam int unsigned MAXO = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          restore;
   logic [DW-1:0] restore_sp;
   logic          ready, done;
   logic [DW-1:0] sp_out;
   logic          req;
   logic [DW-1:0] addr;
   logic          gnt = 1'b0;
   logic          rvalid = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [11:0]   page_off;
   logic          match;

   shadow_register_restore_controller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SHADOW_SAVES(NUM), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .restore_i(restore), .restore_sp_i(restore_sp),
      .restore_ready_o(ready), .restore_done_o(done), .restore_sp_o(sp_out),
      .dreq_req_o(req), .dreq_addr_o(addr), .dreq_gnt_i(gnt),
      .drsp_valid_i(rvalid), .drsp_data_i(rdata),
      .shadow_reg_we_o(we), .shadow_reg_waddr_o(waddr), .shadow_reg_wdata_o(wdata),
      .page_offset_i(page_off), .page_offset_matches_o(match)
   );

   initial forever #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scenario configuration, written only by the main sequence while idle.
   logic [DW-1:0] cur_base = '0;
   logic [DW-1:0] seed = '0;
   int            lat = 1;
   logic [DW-1:0] hold_addr = '1;
   int            hold_total = 0;
   int            stray_req = 0;

   // Dcache responder: grants, in-order responses after lat cycles, stray pulses.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rsp_t;
   rsp_t          pending[$];
   rsp_t          pe;
   int            cyc = 0;
   int            hold_used = 0;
   int            stray_done = 0;
   logic          last_gnt = 1'b0;
   logic          cur_real = 1'b0;
   logic [DW-1:0] last_data = '0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         pending.delete();
         gnt = 1'b0; rvalid = 1'b0; rdata = '0;
         last_gnt = 1'b0; cur_real = 1'b0;
      end else begin
         if (rvalid && cur_real && pending.size() > 0) void'(pending.pop_front());
         if (last_gnt) begin
            pe.due = cyc - 1 + lat; pe.data = last_data;
            pending.push_back(pe);
         end
         if (stray_req != stray_done) begin
            stray_done++;
            rvalid = 1'b1; rdata = 32'hDEAD_BEEF; cur_real = 1'b0;
         end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            rvalid = 1'b1; rdata = pending[0].data; cur_real = 1'b1;
         end else begin
            rvalid = 1'b0; rdata = '0; cur_real = 1'b0;
         end
         if (req && addr == hold_addr && hold_used < hold_total) begin
            hold_used++;
            gnt = 1'b0;
         end else begin
            gnt = req;
         end
         last_gnt  = gnt;
         last_data = seed + ((addr - cur_base) >> 2);
      end
   end

   // Monitor: grant order/addresses, request stability, throttling, write scoreboard.
   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
   } wr_t;
   wr_t           exp_q[$];
   wr_t           e;
   int            gcnt = 0, wcnt = 0, outst = 0, done_cnt = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_addr = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         gcnt = 0; wcnt = 0; outst = 0; prev_hold = 1'b0;
      end else begin
         if (restore && ready) begin
            gcnt = 0; wcnt = 0;
         end
         if (prev_hold) check("req_stable", {req, addr}, {1'b1, prev_addr});
         if (outst >= int'(MAXO)) check("req_throttle", req, 0);
         if (req && gnt) begin
            check("grant_addr", addr, cur_base + 32'(gcnt) * 4);
            e.idx = AW'(gcnt); e.data = seed + 32'(gcnt);
            exp_q.push_back(e);
            gcnt++; outst++;
            check("outstanding_max", 64'(outst <= int'(MAXO)), 1);
         end
         if (we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", we, 0);
            end else begin
               e = exp_q.pop_front();
               check("write", {waddr, wdata}, {e.idx, e.data});
            end
            wcnt++; outst--;
         end
         if (done) done_cnt++;
         prev_hold = req && !gnt;
         prev_addr = addr;
      end
   end

   task automatic start_restore(input logic [DW-1:0] raw_sp, input logic [DW-1:0] s, input int l);
      cur_base = raw_sp & ~32'h3; seed = s; lat = l;
      @(posedge clk); #2 restore = 1'b1; restore_sp = raw_sp;
      @(negedge clk);
      check("idle_no_req", req, 0);
      check("ready_idle", ready, 1);
      @(posedge clk); #2 restore = 1'b0; restore_sp = '0;
      @(negedge clk);
      check("first_req_T1", {req, addr}, {1'b1, cur_base});
      check("busy_not_ready", ready, 0);
   endtask

   task automatic wait_done(input logic [DW-1:0] exp_sp, input string tag);
      int d0 = done_cnt;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk); #1;
         if (done) break;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_sp"}, sp_out, exp_sp);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_writes"}, wcnt, NUM);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
      @(negedge clk); #1;
      check({tag, "_done_single"}, done, 0);
      check({tag, "_done_count"}, done_cnt - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; restore = 1'b0; restore_sp = '0; page_off = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_sp", sp_out, 0);
      check("rst_req", {req, addr}, 0);
      check("rst_we", {we, waddr, wdata}, 0);
      check("rst_match", match, 0);

      // 1: back-to-back grants, one-cycle response latency.
      start_restore(32'h8000_1000, 32'hA0, 1);
      wait_done(32'h8000_1040, "t1");

      // 2: slow responses throttle requests at two outstanding.
      start_restore(32'h8000_1000, 32'hB0, 5);
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #3;
         if (outst == int'(MAXO)) break;
      end
      check("t2_two_outstanding", outst, MAXO);
      check("t2_req_drop", req, 0);
      wait_done(32'h8000_1040, "t2");

      // 3: grant withheld for three cycles on word 4.
      hold_addr = 32'h8000_1010; hold_total = 3;
      start_restore(32'h8000_1000, 32'hC0, 1);
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #3;
         if (req && addr == hold_addr) break;
      end
      for (int i = 0; i < 3; i++) begin
         check("t3_hold", {req, addr, gnt}, {1'b1, hold_addr, 1'b0});
         @(posedge clk); #3;
      end
      check("t3_grant", {req, addr, gnt}, {1'b1, hold_addr, 1'b1});
      wait_done(32'h8000_1040, "t3");

      // 4: reset after seven writes, stray response, then a fresh restore.
      start_restore(32'h8000_1000, 32'hD0, 1);
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #3;
         if (wcnt >= 7) break;
      end
      check("t4_seven_writes", 64'(wcnt >= 7), 1);
      rst = 1'b1;
      @(posedge clk); #3 rst = 1'b0;
      @(negedge clk);
      check("t4_rst_ready", ready, 1);
      check("t4_rst_req", req, 0);
      check("t4_rst_sp", sp_out, 0);
      stray_req++;
      @(posedge clk); #3;
      check("t4_stray_no_write", we, 0);
      check("t4_stray_ready", ready, 1);
      start_restore(32'h0000_2000, 32'hE0, 1);
      wait_done(32'h0000_2040, "t4");

      // 5: second trigger mid-restore is ignored; unaligned base is aligned.
      start_restore(32'h4000_0103, 32'h50, 1);
      @(posedge clk); #2 restore = 1'b1; restore_sp = 32'h1234_5670;
      @(posedge clk); #2 restore = 1'b0; restore_sp = '0;
      wait_done(32'h4000_0140, "t5");

      // 6: page-offset match over a frame that wraps the 4 KiB page.
      start_restore(32'h0000_0FF8, 32'h60, 1);
      page_off = 12'hFF8; #1 check("t6_ff8", match, 1);
      page_off = 12'h020; #1 check("t6_020", match, 1);
      page_off = 12'h040; #1 check("t6_040", match, 0);
      page_off = 12'h034; #1 check("t6_034", match, 1);
      page_off = 12'h038; #1 check("t6_038", match, 0);
      page_off = 12'hFF0; #1 check("t6_ff0", match, 0);
      wait_done(32'h0000_1038, "t6");
      page_off = 12'hFF8; #1 check("t6_idle_nomatch", match, 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
